// File: rtl/alu_pkg.sv
// Shared ALU encodings and the issue-entry record passed from the issue stage to the ALU.
package alu_pkg;

  localparam logic [5:0] ALUC_ADD  = 6'b100000;
  localparam logic [5:0] ALUC_ADDU = 6'b100001;
  localparam logic [5:0] ALUC_SUB  = 6'b100010;
  localparam logic [5:0] ALUC_SUBU = 6'b100011;
  localparam logic [5:0] ALUC_AND  = 6'b100100;
  localparam logic [5:0] ALUC_OR   = 6'b100101;
  localparam logic [5:0] ALUC_XOR  = 6'b100110;
  localparam logic [5:0] ALUC_NOR  = 6'b100111;
  localparam logic [5:0] ALUC_SLT  = 6'b101010;
  localparam logic [5:0] ALUC_SLTU = 6'b101011;
  localparam logic [5:0] ALUC_SLL  = 6'b000000;
  localparam logic [5:0] ALUC_SRL  = 6'b000010;
  localparam logic [5:0] ALUC_SRA  = 6'b000011;
  localparam logic [5:0] ALUC_SLLV = 6'b000100;
  localparam logic [5:0] ALUC_SRLV = 6'b000110;
  localparam logic [5:0] ALUC_SRAV = 6'b000111;
  localparam logic [5:0] ALUC_LUI  = 6'b001111;
  localparam logic [5:0] ALUC_JR   = 6'b001000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  typedef struct packed {
    logic [5:0]  aluc;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
  } issue_entry_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] zext16(input logic [15:0] v);
    return {16'h0000, v};
  endfunction

endpackage

// File: rtl/alu_issue_skid.sv
// Two-entry valid/ready FIFO with a registered head entry, registered valid and registered ready.
module alu_issue_skid
  import alu_pkg::*;
#(
  parameter type T = issue_entry_t
) (
  input  logic clk,
  input  logic rst,
  input  logic i_valid,
  output logic o_ready,
  input  T     i_data,
  output logic o_valid,
  input  logic i_ready,
  output T     o_data
);

  logic [1:0] r_count;
  T           r_head;
  T           r_tail;
  logic       r_valid;
  logic       r_ready;
  logic       w_push;
  logic       w_pop;
  logic [1:0] w_count_nxt;
  T           w_head_nxt;
  T           w_tail_nxt;

  assign w_push  = i_valid & r_ready;
  assign w_pop   = r_valid & i_ready;
  assign o_ready = r_ready;
  assign o_valid = r_valid;
  assign o_data  = r_head;

  // Head always holds the oldest entry; a push onto a full buffer cannot happen since ready is low.
  always_comb begin
    w_count_nxt = r_count;
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    case (r_count)
      2'd0: begin
        if (w_push) begin
          w_head_nxt  = i_data;
          w_count_nxt = 2'd1;
        end else begin
          w_count_nxt = 2'd0;
        end
      end
      2'd1: begin
        if (w_push && w_pop) begin
          w_head_nxt = i_data;
        end else if (w_push) begin
          w_tail_nxt  = i_data;
          w_count_nxt = 2'd2;
        end else if (w_pop) begin
          w_count_nxt = 2'd0;
        end else begin
          w_count_nxt = 2'd1;
        end
      end
      2'd2: begin
        if (w_pop) begin
          w_head_nxt  = r_tail;
          w_count_nxt = 2'd1;
        end else begin
          w_count_nxt = 2'd2;
        end
      end
      default: begin
        w_count_nxt = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 2'd0;
      r_head  <= '0;
      r_tail  <= '0;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_count <= w_count_nxt;
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
      r_valid <= (w_count_nxt != 2'd0);
      r_ready <= (w_count_nxt != 2'd2);
    end
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decodes a MIPS word plus register operands into aluc/a/b/rd and
// queues the result in a 2-entry skid buffer; non-ALU words are flagged and counted.
module alu_issue
  import alu_pkg::*;
#(
  parameter bit DROP_RD0 = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_rs_val,
  input  logic [31:0]      in_rt_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       out_aluc,
  output logic [31:0]      out_a,
  output logic [31:0]      out_b,
  output logic [4:0]       out_rd,
  output logic             illegal,
  output logic [31:0]      illegal_instr,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  logic [5:0]       w_op;
  logic [5:0]       w_funct;
  logic [15:0]      w_imm;
  logic             w_legal;
  logic             w_accept;
  logic             w_drop;
  logic             w_enq;
  logic             w_unused_rs_field;
  issue_entry_t     w_entry;
  issue_entry_t     w_head;
  logic             r_illegal;
  logic [31:0]      r_illegal_instr;
  logic [CNT_W-1:0] r_issued_cnt;
  logic [CNT_W-1:0] r_illegal_cnt;

  assign w_op              = in_instr[31:26];
  assign w_funct           = in_instr[5:0];
  assign w_imm             = in_instr[15:0];
  assign w_unused_rs_field = ^in_instr[25:21];

  // The rs field is unused: the register file has already resolved it into in_rs_val.
  always_comb begin
    w_entry = '0;
    w_legal = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        w_entry.aluc = w_funct;
        w_entry.rd   = in_instr[15:11];
        w_entry.b    = in_rt_val;
        case (w_funct)
          ALUC_SLL, ALUC_SRL, ALUC_SRA: begin
            w_entry.a = {27'd0, in_instr[10:6]};
            w_legal   = 1'b1;
          end
          ALUC_ADD, ALUC_ADDU, ALUC_SUB, ALUC_SUBU, ALUC_AND, ALUC_OR, ALUC_XOR,
          ALUC_NOR, ALUC_SLT, ALUC_SLTU, ALUC_SLLV, ALUC_SRLV, ALUC_SRAV: begin
            w_entry.a = in_rs_val;
            w_legal   = 1'b1;
          end
          default: begin
            w_entry.a = in_rs_val;
            w_legal   = 1'b0;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
        w_legal   = 1'b1;
        w_entry.a = in_rs_val;
        w_entry.rd = in_instr[20:16];
        case (w_op)
          OP_ADDI:  begin w_entry.aluc = ALUC_ADD;  w_entry.b = sext16(w_imm); end
          OP_ADDIU: begin w_entry.aluc = ALUC_ADDU; w_entry.b = sext16(w_imm); end
          OP_SLTI:  begin w_entry.aluc = ALUC_SLT;  w_entry.b = sext16(w_imm); end
          OP_SLTIU: begin w_entry.aluc = ALUC_SLTU; w_entry.b = sext16(w_imm); end
          OP_ANDI:  begin w_entry.aluc = ALUC_AND;  w_entry.b = zext16(w_imm); end
          OP_ORI:   begin w_entry.aluc = ALUC_OR;   w_entry.b = zext16(w_imm); end
          default:  begin w_entry.aluc = ALUC_XOR;  w_entry.b = zext16(w_imm); end
        endcase
      end
      OP_LUI: begin
        w_legal      = 1'b1;
        w_entry.aluc = ALUC_LUI;
        w_entry.a    = zext16(w_imm);
        w_entry.b    = 32'd0;
        w_entry.rd   = in_instr[20:16];
      end
      default: begin
        w_legal = 1'b0;
      end
    endcase
  end

  assign w_accept = in_valid & in_ready;
  assign w_drop   = DROP_RD0 && (w_entry.rd == 5'd0);
  assign w_enq    = w_accept & w_legal & ~w_drop;

  alu_issue_skid #(
    .T(issue_entry_t)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_enq),
    .o_ready (in_ready),
    .i_data  (w_entry),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (w_head)
  );

  assign out_aluc = w_head.aluc;
  assign out_a    = w_head.a;
  assign out_b    = w_head.b;
  assign out_rd   = w_head.rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_illegal       <= 1'b0;
      r_illegal_instr <= 32'd0;
      r_illegal_cnt   <= '0;
      r_issued_cnt    <= '0;
    end else begin
      r_illegal <= w_accept & ~w_legal;
      if (w_accept && !w_legal) begin
        r_illegal_instr <= in_instr;
        r_illegal_cnt   <= r_illegal_cnt + CNT_W'(1);
      end
      if (out_valid && out_ready) begin
        r_issued_cnt <= r_issued_cnt + CNT_W'(1);
      end
    end
  end

  assign illegal       = r_illegal;
  assign illegal_instr = r_illegal_instr;
  assign issued_cnt    = r_issued_cnt;
  assign illegal_cnt   = r_illegal_cnt;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: expected entries are queued on accept and compared on output transfer.
module tb_alu_issue;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs_val;
  logic [31:0] in_rt_val;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_aluc;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [4:0]  out_rd;
  logic        illegal;
  logic [31:0] illegal_instr;
  logic [15:0] issued_cnt;
  logic [15:0] illegal_cnt;

  alu_issue #(.DROP_RD0(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_aluc(out_aluc), .out_a(out_a), .out_b(out_b), .out_rd(out_rd),
    .illegal(illegal), .illegal_instr(illegal_instr),
    .issued_cnt(issued_cnt), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           failures = 0;
  issue_entry_t exp_q[$];
  issue_entry_t cur_exp;
  int           cur_kind;      // 0 = issued, 1 = illegal, 2 = silently dropped
  logic         exp_ill = 1'b0;
  int           exp_issued = 0;
  int           exp_illcnt = 0;
  logic [31:0]  exp_ill_instr = 32'd0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1: check this cycle's outputs, model the coming edge, then advance.
  task automatic clk_step();
    issue_entry_t got;
    issue_entry_t e;
    chk("illegal_pulse", {127'd0, illegal}, {127'd0, exp_ill});
    chk("out_valid", {127'd0, out_valid}, {127'd0, (exp_q.size() != 0)});
    if (out_valid && out_ready) begin
      got = {out_aluc, out_a, out_b, out_rd};
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 128'd1, 128'd0);
      end else begin
        e = exp_q.pop_front();
        chk("out_entry", {53'd0, got}, {53'd0, e});
      end
      exp_issued++;
    end
    exp_ill = in_valid && in_ready && (cur_kind == 1);
    if (in_valid && in_ready) begin
      if (cur_kind == 0) exp_q.push_back(cur_exp);
      if (cur_kind == 1) begin
        exp_illcnt++;
        exp_ill_instr = in_instr;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic setup_in(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt,
                          input int kind, input logic [5:0] aluc, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
    in_instr  = instr;
    in_rs_val = rs;
    in_rt_val = rt;
    cur_kind  = kind;
    cur_exp   = {aluc, a, b, rd};
    in_valid  = 1'b1;
  endtask

  task automatic wait_accept();
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 20; i++) begin
      acc = in_ready;
      clk_step();
      if (acc) break;
    end
    if (!acc) chk("accept_timeout", 128'd0, 128'd1);
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt,
                      input int kind, input logic [5:0] aluc, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] rd);
    setup_in(instr, rs, rt, kind, aluc, a, b, rd);
    wait_accept();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = 32'd0; in_rs_val = 32'd0; in_rt_val = 32'd0; cur_kind = 0; cur_exp = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("rst_out_fields", {53'd0, out_aluc, out_a, out_b, out_rd}, 128'd0);
    chk("rst_illegal", {127'd0, illegal}, 128'd0);
    chk("rst_illegal_instr", {96'd0, illegal_instr}, 128'd0);
    chk("rst_counters", {96'd0, issued_cnt, illegal_cnt}, 128'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Illegal words: JR and an unknown opcode.
    send(32'h03E00008, 32'h1, 32'h2, 1, 6'd0, 32'd0, 32'd0, 5'd0);
    send(32'hFC000000, 32'h1, 32'h2, 1, 6'd0, 32'd0, 32'd0, 5'd0);
    clk_step();
    clk_step();
    chk("illegal_instr", {96'd0, illegal_instr}, {96'd0, exp_ill_instr});
    chk("illegal_instr_const", {96'd0, illegal_instr}, {96'd0, 32'hFC000000});
    chk("illegal_cnt", {112'd0, illegal_cnt}, {112'd0, 16'(exp_illcnt)});
    chk("illegal_cnt_two", {112'd0, illegal_cnt}, 128'd2);
    chk("issued_after_illegal", {112'd0, issued_cnt}, 128'd0);

    // Legal ops with free-flowing output.
    send(32'h00221820, 32'd5, 32'd7, 0, 6'b100000, 32'd5, 32'd7, 5'd3);
    clk_step();
    send(32'h2022FFFF, 32'h10, 32'h99, 0, 6'b100000, 32'h10, 32'hFFFFFFFF, 5'd2);
    send(32'h3022FFFF, 32'h10, 32'h99, 0, 6'b100100, 32'h10, 32'h0000FFFF, 5'd2);
    send(32'h00031100, 32'hDEAD, 32'h11, 0, 6'b000000, 32'd4, 32'h11, 5'd2);
    send(32'h3C051234, 32'hABC, 32'h5, 0, 6'b001111, 32'h00001234, 32'd0, 5'd5);
    send(32'h00221822, 32'd9, 32'd4, 0, 6'b100010, 32'd9, 32'd4, 5'd3);
    send(32'h2C228000, 32'd1, 32'd0, 0, 6'b101011, 32'd1, 32'hFFFF8000, 5'd2);
    send(32'h34228000, 32'd1, 32'd0, 0, 6'b100101, 32'd1, 32'h00008000, 5'd2);
    send(32'h00000000, 32'd1, 32'd2, 2, 6'd0, 32'd0, 32'd0, 5'd0);
    repeat (3) clk_step();
    chk("issued_cnt_flow", {112'd0, issued_cnt}, {112'd0, 16'(exp_issued)});
    chk("issued_cnt_flow_abs", {112'd0, issued_cnt}, 128'd8);

    // Backpressure: two fill the buffer, the third waits until the output drains.
    out_ready = 1'b0;
    send(32'h00221820, 32'd1, 32'd2, 0, 6'b100000, 32'd1, 32'd2, 5'd3);
    send(32'h34228000, 32'd3, 32'd4, 0, 6'b100101, 32'd3, 32'h00008000, 5'd2);
    chk("full_in_ready", {127'd0, in_ready}, 128'd0);
    setup_in(32'h38221234, 32'd5, 32'd6, 0, 6'b100110, 32'd5, 32'h00001234, 5'd2);
    clk_step();
    clk_step();
    chk("held_in_ready", {127'd0, in_ready}, 128'd0);
    chk("stall_stable", {53'd0, out_aluc, out_a, out_b, out_rd},
        {53'd0, 6'b100000, 32'd1, 32'd2, 5'd3});
    out_ready = 1'b1;
    wait_accept();
    repeat (3) clk_step();
    chk("issued_cnt_bp", {112'd0, issued_cnt}, {112'd0, 16'(exp_issued)});
    chk("issued_cnt_bp_abs", {112'd0, issued_cnt}, 128'd11);

    // Asynchronous reset while entries are in flight.
    out_ready = 1'b0;
    send(32'h00221820, 32'd1, 32'd2, 0, 6'b100000, 32'd1, 32'd2, 5'd3);
    send(32'h00221820, 32'd3, 32'd4, 0, 6'b100000, 32'd3, 32'd4, 5'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("mid_rst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("mid_rst_counters", {96'd0, issued_cnt, illegal_cnt}, 128'd0);
    chk("mid_rst_out_fields", {53'd0, out_aluc, out_a, out_b, out_rd}, 128'd0);
    exp_q.delete();
    exp_issued = 0; exp_illcnt = 0; exp_ill_instr = 32'd0; exp_ill = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send(32'h3C051234, 32'd0, 32'd0, 0, 6'b001111, 32'h00001234, 32'd0, 5'd5);
    clk_step();
    clk_step();
    chk("issued_after_rst", {112'd0, issued_cnt}, 128'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
